ov5640_bin_capture: RTL and testbench

Parametrised single-shot binary capture engine for the OV5640 DVP port, successor to the fixed-format capture path.
- Assembles RGB565 pixels from byte pairs and crops a programmable window with power-of-two subsampling.
- Thresholds each pixel to 1 bit and packs PACK_W bits per word into a CPU-visible BRAM.
- Runs entirely in the camera pixel clock domain, between the DVP pins and the AXI BRAM write port.

---
 rtl/ov5640_bin_capture.sv | 240 ++++++++++++++++++++++++
 tb/tb_ov5640_bin_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_bin_capture.sv
// ov5640_bin_capture
// Single-shot binary capture engine on the OV5640 DVP port. Bytes are paired
// into RGB565 pixels, a programmable window is cropped with power-of-two
// subsampling, each kept pixel is thresholded on a cheap luma estimate, and
// the resulting bits are packed LSB-first into PACK_W-bit BRAM words.
// Everything runs on the camera pixel clock.
//
// Optional build macro: CAP_ROW_ALIGN_EN -- when defined, each window row
// that leaves a partial word is flushed zero-padded so rows start word-aligned.
//
// Ports:
//   ov5640_pclk   pixel clock (rising edge)       sys_rst      async active-high reset
//   ov5640_sync   VSYNC, high in frame blanking   ov5640_href  line valid
//   ov5640_data   DVP byte, RGB565 high byte first
//   cap_req       start a capture (IDLE/DONE only)
//   cap_done      capture complete (level)        cap_overflow window exceeded BRAM
//   cfg_*         threshold, window origin/size, subsample exponent (latched at start)
//   bram_wen/bram_waddr/bram_wdata  one-cycle word write to the BRAM port
module ov5640_bin_capture #(
    parameter int PACK_W = 20,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 11
) (
    input  logic              ov5640_pclk,
    input  logic              sys_rst,
    input  logic              ov5640_sync,
    input  logic              ov5640_href,
    input  logic [7:0]        ov5640_data,
    input  logic              cap_req,
    output logic              cap_done,
    output logic              cap_overflow,
    input  logic [7:0]        cfg_threshold,
    input  logic [CNT_W-1:0]  cfg_x0,
    input  logic [CNT_W-1:0]  cfg_y0,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic [1:0]        cfg_skip,
    output logic              bram_wen,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [PACK_W-1:0] bram_wdata
);

    // One extra bit so x0+width / y0+height never wrap.
    localparam int CW  = CNT_W + 1;
    localparam int PCW = $clog2(PACK_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BLANK, S_WAIT_FRAME, S_CAPTURE, S_FLUSH, S_DONE
    } state_t;

    state_t             r_state;
    logic [7:0]         r_thr;
    logic [CNT_W-1:0]   r_x0, r_y0, r_w, r_h;
    logic [1:0]         r_skip;
    logic               r_href_d;
    logic               r_phase;
    logic [7:0]         r_hi;
    logic [CW-1:0]      r_col, r_row;
    logic [PACK_W-1:0]  r_pack;
    logic [PCW-1:0]     r_pcnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_full;     // last BRAM address has been written
    logic               r_wen;
    logic [ADDR_W-1:0]  r_waddr;
    logic [PACK_W-1:0]  r_wdata;
    logic               r_done;
    logic               r_ovf;

    logic [4:0]         w_r, w_b;
    logic [5:0]         w_g;
    logic [7:0]         w_luma;
    logic               w_bit;
    logic               w_pix_done;
    logic [CW-1:0]      w_x_end, w_y_end, w_dx, w_dy;
    logic [2:0]         w_mask;
    logic               w_keep;
    logic               w_row_end;
    logic               w_last_row;
    logic               w_pack_full;
    logic [PACK_W-1:0]  w_ins;
    logic               w_start;
    logic               w_wr_due;
    logic [PACK_W-1:0]  w_wr_word;

    assign cap_done     = r_done;
    assign cap_overflow = r_ovf;
    assign bram_wen     = r_wen;
    assign bram_waddr   = r_waddr;
    assign bram_wdata   = r_wdata;

    // Pixel completes on the low byte; the high byte is already in r_hi.
    assign w_pix_done = ov5640_href & r_phase;
    assign w_r        = r_hi[7:3];
    assign w_g        = {r_hi[2:0], ov5640_data[7:5]};
    assign w_b        = ov5640_data[4:0];
    assign w_luma     = {2'b00, w_r, 1'b0} + {2'b00, w_g} + {2'b00, w_b, 1'b0};
    assign w_bit      = (w_luma >= r_thr);

    assign w_x_end = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_end = {1'b0, r_y0} + {1'b0, r_h};
    assign w_dx    = r_col - {1'b0, r_x0};
    assign w_dy    = r_row - {1'b0, r_y0};
    assign w_mask  = ~(3'b111 << r_skip);
    assign w_keep  = ({1'b0, r_x0} <= r_col) && (r_col < w_x_end) &&
                     ({1'b0, r_y0} <= r_row) && (r_row < w_y_end) &&
                     ((w_dx[2:0] & w_mask) == 3'b000) &&
                     ((w_dy[2:0] & w_mask) == 3'b000);

    assign w_row_end = r_href_d & ~ov5640_href;
    // An empty window never ends on a row; it waits for the frame end.
    assign w_last_row = w_row_end && ((r_row + CW'(1)) == w_y_end) &&
                        (r_w != '0) && (r_h != '0);

    assign w_pack_full = (r_pcnt == PCW'(PACK_W - 1));
    assign w_ins       = r_pack | (PACK_W'(w_bit) << r_pcnt);
    assign w_start     = cap_req && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_wr_due  = 1'b0;
        w_wr_word = r_pack;
        if (r_state == S_CAPTURE && w_pix_done && w_keep && w_pack_full) begin
            w_wr_due  = 1'b1;
            w_wr_word = w_ins;
        end
        if (r_state == S_FLUSH && r_pcnt != '0)
            w_wr_due = 1'b1;
`ifdef CAP_ROW_ALIGN_EN
        // The final row's partial word is left to FLUSH.
        if (r_state == S_CAPTURE && w_row_end && !w_last_row && r_pcnt != '0)
            w_wr_due = 1'b1;
`endif
    end

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= S_IDLE;
            r_thr    <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_skip   <= '0;
            r_href_d <= 1'b0;
            r_phase  <= 1'b0;
            r_hi     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_pack   <= '0;
            r_pcnt   <= '0;
            r_addr   <= '0;
            r_full   <= 1'b0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wen    <= 1'b0;
            r_href_d <= ov5640_href;
            r_phase  <= ov5640_href ? ~r_phase : 1'b0;
            if (ov5640_href && !r_phase)
                r_hi <= ov5640_data;

            // Once the top address is written, further words only flag overflow.
            if (w_wr_due) begin
                if (r_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wen   <= 1'b1;
                    r_waddr <= r_addr;
                    r_wdata <= w_wr_word;
                    r_addr  <= r_addr + ADDR_W'(1);
                    if (r_addr == '1)
                        r_full <= 1'b1;
                end
            end

            if (w_start) begin
                r_state <= S_WAIT_BLANK;
                r_thr   <= cfg_threshold;
                r_x0    <= cfg_x0;
                r_y0    <= cfg_y0;
                r_w     <= cfg_width;
                r_h     <= cfg_height;
                r_skip  <= cfg_skip;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
                r_addr  <= '0;
                r_full  <= 1'b0;
                r_pack  <= '0;
                r_pcnt  <= '0;
            end else begin
                case (r_state)
                    S_WAIT_BLANK: if (ov5640_sync) r_state <= S_WAIT_FRAME;
                    S_WAIT_FRAME: begin
                        if (!ov5640_sync) begin
                            r_state <= S_CAPTURE;
                            r_col   <= '0;
                            r_row   <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_pix_done) begin
                            r_col <= r_col + CW'(1);
                            if (w_keep) begin
                                if (w_pack_full) begin
                                    r_pack <= '0;
                                    r_pcnt <= '0;
                                end else begin
                                    r_pack <= w_ins;
                                    r_pcnt <= r_pcnt + PCW'(1);
                                end
                            end
                        end
                        if (w_row_end) begin
                            r_col <= '0;
                            r_row <= r_row + CW'(1);
`ifdef CAP_ROW_ALIGN_EN
                            if (!w_last_row) begin
                                r_pack <= '0;
                                r_pcnt <= '0;
                            end
`endif
                        end
                        if (w_last_row || ov5640_sync)
                            r_state <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        r_pack  <= '0;
                        r_pcnt  <= '0;
                        r_state <= S_DONE;
                    end
                    S_DONE:  r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov5640_bin_capture.sv
module tb_ov5640_bin_capture;

    localparam int PACK_W = 20;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              rst, sync, href, cap_req;
    logic [7:0]        data, thr;
    logic              cap_done, cap_ovf, wen;
    logic [CNT_W-1:0]  x0, y0, wd, ht;
    logic [1:0]        skip;
    logic [ADDR_W-1:0] waddr;
    logic [PACK_W-1:0] wdata;

    ov5640_bin_capture #(.PACK_W(PACK_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .ov5640_pclk(clk), .sys_rst(rst), .ov5640_sync(sync), .ov5640_href(href),
        .ov5640_data(data), .cap_req(cap_req), .cap_done(cap_done),
        .cap_overflow(cap_ovf), .cfg_threshold(thr), .cfg_x0(x0), .cfg_y0(y0),
        .cfg_width(wd), .cfg_height(ht), .cfg_skip(skip), .bram_wen(wen),
        .bram_waddr(waddr), .bram_wdata(wdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0]       pix [0:15][0:63];
    int                obs_a[$];
    logic [PACK_W-1:0] obs_d[$];
    int                exp_a[$];
    logic [PACK_W-1:0] exp_d[$];
    bit                exp_ovf;

    always @(negedge clk) begin
        if (wen) begin
            obs_a.push_back(int'(waddr));
            obs_d.push_back(wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int luma(input logic [15:0] p);
        return 2 * int'(p[15:11]) + int'(p[10:5]) + 2 * int'(p[4:0]);
    endfunction

    // Reference: list every kept bit in raster order, then cut into words.
    task automatic build_model(input int fw, input int fh, input int xi, input int yi,
                               input int wi, input int hi, input int sk, input int th);
        bit bits[$];
        int step = 1 << sk;
        int nw;
        logic [PACK_W-1:0] word;
        exp_a.delete();
        exp_d.delete();
        exp_ovf = 1'b0;
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++)
                if (c >= xi && c < xi + wi && r >= yi && r < yi + hi &&
                    (c - xi) % step == 0 && (r - yi) % step == 0)
                    bits.push_back(luma(pix[r][c]) >= th);
`ifdef CAP_ROW_ALIGN_EN
            if (r < yi + hi - 1)
                while (bits.size() % PACK_W != 0) bits.push_back(1'b0);
`endif
        end
        nw = (bits.size() + PACK_W - 1) / PACK_W;
        for (int i = 0; i < nw; i++) begin
            word = '0;
            for (int b = 0; b < PACK_W; b++)
                if (i * PACK_W + b < bits.size()) word[b] = bits[i * PACK_W + b];
            if (i < (1 << ADDR_W)) begin
                exp_a.push_back(i);
                exp_d.push_back(word);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++)
                case (mode)
                    0:       pix[r][c] = 16'hFFFF;
                    1:       pix[r][c] = (c % 2 == 0) ? 16'hFFFF : 16'h0000;
                    default: pix[r][c] = 16'($urandom);
                endcase
    endtask

    task automatic send_frame(input int fw, input int fh);
        logic [15:0] p;
        sync = 1'b1;
        repeat (4) tick();
        sync = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++) begin
                p = pix[r][c];
                href = 1'b1;
                data = p[15:8];
                tick();
                data = p[7:0];
                tick();
            end
            href = 1'b0;
            data = 8'h00;
            repeat (3) tick();
        end
        sync = 1'b1;
        repeat (3) tick();
        sync = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input int xi, input int yi, input int wi, input int hi,
                           input int sk, input int th);
        x0   = CNT_W'(xi);
        y0   = CNT_W'(yi);
        wd   = CNT_W'(wi);
        ht   = CNT_W'(hi);
        skip = 2'(sk);
        thr  = 8'(th);
    endtask

    task automatic run_cap(input string tag, input int fw, input int fh, input int xi,
                           input int yi, input int wi, input int hi, input int sk,
                           input int th, input bit req_mid);
        int n;
        int m;
        set_cfg(xi, yi, wi, hi, sk, th);
        build_model(fw, fh, xi, yi, wi, hi, sk, th);
        obs_a.delete();
        obs_d.delete();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        @(negedge clk);
        check({tag, ".done_clr"}, 32'(cap_done), 32'd0);
        tick();
        if (req_mid) begin
            fork
                send_frame(fw, fh);
                begin
                    repeat (40) tick();
                    set_cfg(0, 0, 1, 1, 0, 255);
                    cap_req = 1'b1;
                    tick();
                    cap_req = 1'b0;
                end
            join
        end else begin
            send_frame(fw, fh);
        end
        n = 0;
        while (!cap_done && n < 200) begin
            tick();
            n++;
        end
        check({tag, ".done"}, 32'(cap_done), 32'd1);
        check({tag, ".nwr"}, 32'(obs_a.size()), 32'(exp_a.size()));
        m = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            check({tag, ".addr"}, 32'(obs_a[i]), 32'(exp_a[i]));
            check({tag, ".data"}, 32'(obs_d[i]), 32'(exp_d[i]));
        end
        check({tag, ".ovf"}, 32'(cap_ovf), 32'(exp_ovf));
    endtask

    initial begin
        #900000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nr;
        int fw, fh, xi, yi, wi, hi;
        rst = 1'b1; sync = 1'b0; href = 1'b0; data = '0; cap_req = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        check("rst.wen",   32'(wen),      32'd0);
        check("rst.done",  32'(cap_done), 32'd0);
        check("rst.ovf",   32'(cap_ovf),  32'd0);
        check("rst.waddr", 32'(waddr),    32'd0);
        check("rst.wdata", 32'(wdata),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        fill(0); run_cap("full",    64, 8, 4, 2, 40, 2, 0, 100, 1'b0);
        fill(1); run_cap("alt",     64, 8, 4, 2, 40, 2, 1, 100, 1'b0);
        fill(2); run_cap("partial", 64, 8, 4, 2, 30, 1, 0, 0,   1'b0);
        fill(0); run_cap("ovf",     64, 4, 0, 0, 64, 4, 0, 0,   1'b1);
        fill(2); run_cap("w0",      16, 4, 2, 1, 0,  2, 0, 0,   1'b0);
        fill(2); run_cap("h0",      16, 4, 2, 1, 8,  0, 0, 0,   1'b0);
        fill(2); run_cap("beyond",  16, 4, 10, 2, 20, 10, 0, 50, 1'b0);

        // Reset part-way through a row after one word has been written.
        fill(0);
        set_cfg(0, 0, 64, 4, 0, 0);
        obs_a.delete();
        obs_d.delete();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        nr = 0;
        fork
            send_frame(64, 4);
            begin
                repeat (60) tick();
                rst = 1'b1;
                @(negedge clk);
                check("mrst.wen",   32'(wen),      32'd0);
                check("mrst.done",  32'(cap_done), 32'd0);
                check("mrst.ovf",   32'(cap_ovf),  32'd0);
                check("mrst.waddr", 32'(waddr),    32'd0);
                check("mrst.wdata", 32'(wdata),    32'd0);
                nr = obs_a.size();
                tick();
                rst = 1'b0;
            end
        join
        repeat (20) tick();
        check("mrst.prewr", 32'(nr), 32'd1);
        check("mrst.nowr",  32'(obs_a.size()), 32'(nr));
        check("mrst.idle",  32'(cap_done), 32'd0);

        for (int it = 0; it < 10; it++) begin
            fw = $urandom_range(8, 32);
            fh = $urandom_range(2, 6);
            xi = $urandom_range(0, fw - 1);
            wi = $urandom_range(0, fw);
            yi = $urandom_range(0, fh - 1);
            hi = $urandom_range(0, fh + 1);
            fill(2);
            run_cap("rnd", fw, fh, xi, yi, wi, hi, $urandom_range(0, 3),
                    $urandom_range(0, 190), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
